// File: rtl/mux_byte_sequencer.sv
// rtl/mux_byte_sequencer.sv - byte sequencer driving an external 8:1 mux and serializing its output
// Accepts a byte, walks the mux select through all eight positions and registers each sampled bit.
module mux_byte_sequencer #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] mux_d,
  output logic [2:0] mux_s,
  input  logic       mux_y,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       busy,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [2:0] S_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mux_d_q, mux_d_d;
  logic [2:0]    mux_s_q, mux_s_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_valid_q, ser_valid_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_d_q     <= 8'h00;
      mux_s_q     <= 3'd0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_d_q     <= mux_d_d;
      mux_s_q     <= mux_s_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mux_d_d     = mux_d_q;
    mux_s_d     = mux_s_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mux_d_d   = in_data;
          mux_s_d   = S_FIRST;
          div_cnt_d = '0;
          bit_cnt_d = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // mux_y settles from the registered mux_d/mux_s within the cycle before sampling
        if (div_cnt_q == DIV_LAST) begin
          ser_out_d   = mux_y;
          ser_valid_d = 1'b1;
          div_cnt_d   = '0;
          if (bit_cnt_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mux_s_d   = MSB_FIRST ? (mux_s_q - 3'd1) : (mux_s_q + 3'd1);
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == SHIFT);
  assign mux_d     = mux_d_q;
  assign mux_s     = mux_s_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_byte_sequencer.sv
// tb/tb_mux_byte_sequencer.sv - directed bench for mux_byte_sequencer with behavioural 8:1 mux models
module tb_mux_byte_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: DIV=1 LSB first, u1: DIV=1 MSB first, u2: DIV=4 LSB first
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] i0 = 8'h00, i1 = 8'h00, i2 = 8'h00;
  logic       r0, r1, r2;
  logic [7:0] d0, d1, d2;
  logic [2:0] s0, s1, s2;
  logic       y0, y1, y2;
  logic       so0, so1, so2;
  logic       sv0, sv1, sv2;
  logic       b0, b1, b2;
  logic       dn0, dn1, dn2;

  assign y0 = d0[s0];
  assign y1 = d1[s1];
  assign y2 = d2[s2];

  mux_byte_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(i0),
    .mux_d(d0), .mux_s(s0), .mux_y(y0), .ser_out(so0), .ser_valid(sv0),
    .busy(b0), .done(dn0));

  mux_byte_sequencer #(.DIV(1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(i1),
    .mux_d(d1), .mux_s(s1), .mux_y(y1), .ser_out(so1), .ser_valid(sv1),
    .busy(b1), .done(dn1));

  mux_byte_sequencer #(.DIV(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(i2),
    .mux_d(d2), .mux_s(s2), .mux_y(y2), .ser_out(so2), .ser_valid(sv2),
    .busy(b2), .done(dn2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat;

  initial begin
    // reset held 3 cycles with in_valid asserted everywhere
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    i0 = 8'h5A; i1 = 8'h5A; i2 = 8'h5A;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst_in_ready0", r0, 0);
      check("rst_in_ready2", r2, 0);
      tick();
      check("rst_busy0", b0, 0);
      check("rst_busy2", b2, 0);
      check("rst_mux_d0", d0, 8'h00);
      check("rst_mux_s1", s1, 3'd0);
      check("rst_ser0", {so0, sv0, dn0}, 3'b000);
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_ready0", r0, 1);
    check("post_rst_ready1", r1, 1);
    check("post_rst_busy0", b0, 0);
    check("post_rst_mux_d0", d0, 8'h00);

    // DIV=1 LSB first, 8'h1E
    pat = 8'h1E;
    i0 = pat; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    check("t2_busy", b0, 1);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t2_mux_s%0d", n), s0, n);
      tick();
      check($sformatf("t2_sv%0d", n), sv0, 1);
      check($sformatf("t2_bit%0d", n), so0, pat[n]);
      check($sformatf("t2_done%0d", n), dn0, (n == 7));
      check($sformatf("t2_rdy%0d", n), r0, (n == 7));
    end
    tick();
    check("t2_sv_after", sv0, 0);
    check("t2_done_after", dn0, 0);
    check("t2_s_hold", s0, 3'd7);

    // DIV=1 MSB first, 8'h1E
    i1 = pat; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t3_mux_s%0d", n), s1, 7 - n);
      tick();
      check($sformatf("t3_sv%0d", n), sv1, 1);
      check($sformatf("t3_bit%0d", n), so1, pat[7-n]);
      check($sformatf("t3_done%0d", n), dn1, (n == 7));
    end
    tick();
    check("t3_s_hold", s1, 3'd0);
    check("t3_done_after", dn1, 0);

    // DIV=4 LSB first, 8'hA5
    pat = 8'hA5;
    i2 = pat; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("t4_mux_s_c%0d", c), s2, (c - 1) / 4);
      tick();
      check($sformatf("t4_sv_c%0d", c), sv2, (c % 4 == 0));
      if (c % 4 == 0) check($sformatf("t4_bit_c%0d", c), so2, pat[c/4-1]);
      check($sformatf("t4_done_c%0d", c), dn2, (c == 32));
    end
    tick();
    check("t4_s_hold", s2, 3'd7);

    // in_valid held, data changes mid-byte
    pat = 8'h3C;
    i0 = pat; v0 = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      if (n == 2) i0 = 8'hC3;
      tick();
      check($sformatf("t5_bit%0d", n), so0, pat[n]);
      check($sformatf("t5_busy%0d", n), b0, (n != 7));
      check($sformatf("t5_mux_d%0d", n), d0, 8'h3C);
    end
    check("t5_rdy_at_done", r0, 1);
    tick();
    check("t5_second_accept", b0, 1);
    check("t5_second_data", d0, 8'hC3);
    v0 = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("t5_second_done", dn0, 1);
    tick();

    // reset after third bit aborts the byte
    i0 = 8'hFF; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("t6_sv%0d", n), sv0, 1);
      check($sformatf("t6_bit%0d", n), so0, 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy_after_rst", b0, 0);
    check("t6_mux_d_after_rst", d0, 8'h00);
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("t6_quiet_sv%0d", c), sv0, 0);
      check($sformatf("t6_quiet_done%0d", c), dn0, 0);
    end
    pat = 8'h01;
    i0 = pat; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check($sformatf("t6b_sv%0d", n), sv0, 1);
      check($sformatf("t6b_bit%0d", n), so0, pat[n]);
      check($sformatf("t6b_done%0d", n), dn0, (n == 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
